// File: rtl/result_bcd_converter.sv
// Sequential double-dabble converter: 9-bit subtractor/adder result to sign + three BCD digits.
// One shift per clock; a start in IDLE yields a one-cycle done pulse ten edges later.
module result_bcd_converter #(
  parameter bit SIGNED_IN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [8:0] result,
  output logic       busy,
  output logic       done,
  output logic       neg,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_reg;
  logic [11:0] scratch_reg;
  logic [8:0]  mag_reg;
  logic [3:0]  count_reg;
  logic        neg_r_reg;
  logic [11:0] scratch_adj;

  // Add-3 correction on each BCD nibble before it is shifted.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_adj
      assign scratch_adj[gi*4 +: 4] = (scratch_reg[gi*4 +: 4] >= 4'd5)
                                      ? scratch_reg[gi*4 +: 4] + 4'd3
                                      : scratch_reg[gi*4 +: 4];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      scratch_reg <= '0;
      mag_reg     <= '0;
      count_reg   <= '0;
      neg_r_reg   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      neg         <= 1'b0;
      hundreds    <= '0;
      tens        <= '0;
      ones        <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (SIGNED_IN && result[8]) begin
              neg_r_reg <= 1'b1;
              mag_reg   <= ~result + 9'd1;
            end else begin
              neg_r_reg <= 1'b0;
              mag_reg   <= result;
            end
            scratch_reg <= '0;
            count_reg   <= '0;
            busy        <= 1'b1;
            state_reg   <= SHIFT;
          end
        end
        SHIFT: begin
          {scratch_reg, mag_reg} <= {scratch_adj[10:0], mag_reg, 1'b0};
          count_reg <= count_reg + 4'd1;
          if (count_reg == 4'd8) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          hundreds  <= scratch_reg[11:8];
          tens      <= scratch_reg[7:4];
          ones      <= scratch_reg[3:0];
          neg       <= neg_r_reg;
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule
